// File: rtl/alu_pkg.sv
// Shared opcodes, class/funct3 codes and the issue payload for the ALU operand stage.
// Operand forwarding in alu_operand_stage is enabled by defining ALU_OPERAND_FWD_EN.
package alu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned OPW  = 4;

    localparam logic [OPW-1:0] ALU_SUB = 4'b0000;
    localparam logic [OPW-1:0] ALU_ADD = 4'b0001;
    localparam logic [OPW-1:0] ALU_AND = 4'b0010;
    localparam logic [OPW-1:0] ALU_OR  = 4'b0011;
    localparam logic [OPW-1:0] ALU_SRL = 4'b1100;
    localparam logic [OPW-1:0] ALU_ILL = 4'b1111;

    typedef enum logic [1:0] {
        CLS_MEM   = 2'b00,
        CLS_BR    = 2'b01,
        CLS_RTYPE = 2'b10,
        CLS_ITYPE = 2'b11
    } alu_class_e;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] num1;
        logic [XLEN-1:0] num2;
        logic [OPW-1:0]  alu_op;
        logic            illegal;
    } issue_t;

    // Youngest in-flight writer of a non-zero register wins over the register file.
    function automatic logic [XLEN-1:0] fwd_pick(
        input logic [REGW-1:0] rs,
        input logic [XLEN-1:0] rf_data,
        input logic            exm_we,
        input logic [REGW-1:0] exm_rd,
        input logic [XLEN-1:0] exm_result,
        input logic            mwb_we,
        input logic [REGW-1:0] mwb_rd,
        input logic [XLEN-1:0] mwb_result
    );
        logic [XLEN-1:0] val;
        val = rf_data;
        if (exm_we && (exm_rd == rs) && (rs != '0)) begin
            val = exm_result;
        end else if (mwb_we && (mwb_rd == rs) && (rs != '0)) begin
            val = mwb_result;
        end
        return val;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU opcode decode from instruction class, funct3 and funct7 bit 5.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0]     alu_class,
    input  logic [2:0]     funct3,
    input  logic           funct7b5,
    output logic [OPW-1:0] alu_op_c,
    output logic           illegal_c
);

    always_comb begin
        alu_op_c  = ALU_ADD;
        illegal_c = 1'b0;
        unique case (alu_class_e'(alu_class))
            CLS_MEM: alu_op_c = ALU_ADD;
            CLS_BR:  alu_op_c = ALU_SUB;
            CLS_RTYPE, CLS_ITYPE: begin
                unique case (funct3)
                    // funct7b5 selects sub only for register-register ops
                    F3_ADD: alu_op_c = (alu_class_e'(alu_class) == CLS_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    F3_AND: alu_op_c = ALU_AND;
                    F3_OR:  alu_op_c = ALU_OR;
                    F3_SRL: alu_op_c = ALU_SRL;
                    default: begin
                        alu_op_c  = ALU_ILL;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            default: alu_op_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered issue stage ahead of the ALU: operand select, opcode decode, valid/ready handshake.
// Define ALU_OPERAND_FWD_EN to resolve RAW hazards from EX/MEM and MEM/WB.
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_alu_src,
    input  logic [1:0]      in_alu_class,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic            flush,
    input  logic            exm_we,
    input  logic [REGW-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_we,
    input  logic [REGW-1:0] mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] num1,
    output logic [XLEN-1:0] num2,
    output logic [OPW-1:0]  alu_op,
    output logic            illegal
);

    localparam issue_t RESET_ISSUE = '{num1: '0, num2: '0, alu_op: ALU_ADD, illegal: 1'b0};

    logic [XLEN-1:0] rs1_opnd;
    logic [XLEN-1:0] rs2_opnd;
    logic [OPW-1:0]  dec_op_c;
    logic            dec_ill_c;
    logic            capture;
    logic            valid_nxt;
    issue_t          issue_nxt;
    issue_t          issue_q;
    logic            valid_q;

`ifdef ALU_OPERAND_FWD_EN
    assign rs1_opnd = fwd_pick(in_rs1, in_rs1_data, exm_we, exm_rd, exm_result, mwb_we, mwb_rd, mwb_result);
    assign rs2_opnd = fwd_pick(in_rs2, in_rs2_data, exm_we, exm_rd, exm_result, mwb_we, mwb_rd, mwb_result);
`else
    // Forwarding ports stay on the interface so both builds share one pinout.
    logic unused_fwd;
    assign unused_fwd = ^{in_rs1, in_rs2, exm_we, exm_rd, exm_result, mwb_we, mwb_rd, mwb_result};
    assign rs1_opnd   = in_rs1_data;
    assign rs2_opnd   = in_rs2_data;
`endif

    alu_ctrl_decode u_decode (
        .alu_class (in_alu_class),
        .funct3    (in_funct3),
        .funct7b5  (in_funct7b5),
        .alu_op_c  (dec_op_c),
        .illegal_c (dec_ill_c)
    );

    assign in_ready = !valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    // Next valid and payload; the immediate overrides rs2 after any forwarding.
    always_comb begin
        valid_nxt = valid_q;
        issue_nxt = issue_q;
        if (flush) begin
            valid_nxt = 1'b0;
        end else if (capture) begin
            valid_nxt = 1'b1;
        end else if (out_ready) begin
            valid_nxt = 1'b0;
        end
        if (capture) begin
            issue_nxt.num1    = rs1_opnd;
            issue_nxt.num2    = in_alu_src ? in_imm : rs2_opnd;
            issue_nxt.alu_op  = dec_op_c;
            issue_nxt.illegal = dec_ill_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            issue_q <= RESET_ISSUE;
        end else begin
            valid_q <= valid_nxt;
            issue_q <= issue_nxt;
        end
    end

    assign out_valid = valid_q;
    assign num1      = issue_q.num1;
    assign num2      = issue_q.num2;
    assign alu_op    = issue_q.alu_op;
    assign illegal   = issue_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed cases then randomized traffic against a reference model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
    logic        in_alu_src = 1'b0;
    logic [1:0]  in_alu_class = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7b5 = 1'b0;
    logic        flush = 1'b0;
    logic        exm_we = 1'b0, mwb_we = 1'b0;
    logic [4:0]  exm_rd = '0, mwb_rd = '0;
    logic [31:0] exm_result = '0, mwb_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] num1, num2;
    logic [3:0]  alu_op;
    logic        illegal;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_alu_src(in_alu_src), .in_alu_class(in_alu_class),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .flush(flush),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .num1(num1), .num2(num2), .alu_op(alu_op), .illegal(illegal)
    );

    typedef struct {
        bit          in_valid, out_ready, flush, reset, alu_src, f7, ewe, mwe;
        logic [4:0]  rs1, rs2, erd, mrd;
        logic [31:0] d1, d2, imm, eres, mres;
        logic [1:0]  cls;
        logic [2:0]  f3;
    } stim_t;

    typedef struct {
        logic [31:0] n1, n2;
        logic [3:0]  op;
        bit          ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   after_rst = 1'b1;
    bit   expv;
    exp_t e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register value as seen after applying in-flight writes oldest to youngest.
    function automatic logic [31:0] operand(input stim_t s, input logic [4:0] rs, input logic [31:0] rf);
        logic [31:0] v;
        v = rf;
`ifdef ALU_OPERAND_FWD_EN
        if (rs != 0) begin
            if (s.mwe && s.mrd == rs) v = s.mres;
            if (s.ewe && s.erd == rs) v = s.eres;
        end
`endif
        return v;
    endfunction

    function automatic exp_t ref_model(input stim_t s);
        exp_t  r;
        string mn;
        if (s.cls == 2'd0) mn = "add";
        else if (s.cls == 2'd1) mn = "sub";
        else begin
            case (s.f3)
                3'd0:    mn = (s.cls == 2'd2 && s.f7) ? "sub" : "add";
                3'd7:    mn = "and";
                3'd6:    mn = "or";
                3'd5:    mn = "srl";
                default: mn = "ill";
            endcase
        end
        case (mn)
            "add":   r.op = 4'b0001;
            "sub":   r.op = 4'b0000;
            "and":   r.op = 4'b0010;
            "or":    r.op = 4'b0011;
            "srl":   r.op = 4'b1100;
            default: r.op = 4'b1111;
        endcase
        r.ill = (mn == "ill");
        r.n1  = operand(s, s.rs1, s.d1);
        r.n2  = s.alu_src ? s.imm : operand(s, s.rs2, s.d2);
        return r;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.out_ready = 1'b1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bit acc;
        @(posedge clk); #1;
        reset = s.reset; in_valid = s.in_valid; out_ready = s.out_ready; flush = s.flush;
        in_rs1 = s.rs1; in_rs2 = s.rs2; in_rs1_data = s.d1; in_rs2_data = s.d2; in_imm = s.imm;
        in_alu_src = s.alu_src; in_alu_class = s.cls; in_funct3 = s.f3; in_funct7b5 = s.f7;
        exm_we = s.ewe; exm_rd = s.erd; exm_result = s.eres;
        mwb_we = s.mwe; mwb_rd = s.mrd; mwb_result = s.mres;
        acc = s.in_valid && (sb.size() == 0 || s.out_ready) && !s.flush && !s.reset;
        @(negedge clk); #1;
        if (acc) sb.push_back(ref_model(s));
    endtask

    // Monitor: compares presented outputs with the scoreboard head; retires it on consume/flush/reset.
    always @(negedge clk) begin
        expv = (sb.size() != 0);
        check("out_valid", 64'(out_valid), 64'(expv));
        check("in_ready", 64'(in_ready), 64'(!expv || out_ready));
        if (expv) begin
            e = sb[0];
            check("num1", 64'(num1), 64'(e.n1));
            check("num2", 64'(num2), 64'(e.n2));
            check("alu_op", 64'(alu_op), 64'(e.op));
            check("illegal", 64'(illegal), 64'(e.ill));
        end else if (after_rst) begin
            check("rst_num1", 64'(num1), 64'd0);
            check("rst_num2", 64'(num2), 64'd0);
            check("rst_alu_op", 64'(alu_op), 64'd1);
            check("rst_illegal", 64'(illegal), 64'd0);
        end
        if (reset) sb.delete();
        else if (expv && (out_ready || flush)) void'(sb.pop_front());
        after_rst = reset;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        // Case 1: R-type sub
        s = idle(); s.in_valid = 1; s.cls = 2'b10; s.f3 = 3'b000; s.f7 = 1;
        s.rs1 = 5'd1; s.rs2 = 5'd2; s.d1 = 32'd7; s.d2 = 32'd3; s.out_ready = 0;
        drive(s);
        // Case 2: I-type or with immediate
        s = idle(); s.in_valid = 1; s.cls = 2'b11; s.f3 = 3'b110; s.imm = 32'hF0; s.alu_src = 1;
        s.d2 = 32'hDEAD_BEEF;
        drive(s);
        // Case 3: stall two cycles with new traffic waiting, then accept
        s.out_ready = 0; s.cls = 2'b10; s.f3 = 3'b111; s.alu_src = 0; s.d1 = 32'h1234; s.d2 = 32'h5678;
        drive(s);
        drive(s);
        s.out_ready = 1;
        drive(s);
        // Case 4: flush while holding, with a valid incoming entry
        s = idle(); s.in_valid = 1; s.out_ready = 0; s.cls = 2'b00; s.d1 = 32'h11; s.d2 = 32'h22;
        drive(s);
        s.flush = 1; s.d1 = 32'h33;
        drive(s);
        s = idle();
        drive(s);
        // Case 5: double-match forwarding, and r0 never forwarded
        s = idle(); s.in_valid = 1; s.rs1 = 5'd5; s.d1 = 32'h99;
        s.ewe = 1; s.erd = 5'd5; s.eres = 32'hAA; s.mwe = 1; s.mrd = 5'd5; s.mres = 32'hBB;
        drive(s);
        s.rs1 = 5'd0; s.erd = 5'd0; s.mrd = 5'd0; s.d1 = 32'h77;
        drive(s);
        // Case 6: illegal funct3, then reset while it is held
        s = idle(); s.in_valid = 1; s.cls = 2'b10; s.f3 = 3'b001; s.out_ready = 0;
        drive(s);
        s = idle(); s.in_valid = 1; s.out_ready = 0; s.reset = 1;
        drive(s);
        s = idle();
        drive(s);
        // Class 11 add ignores funct7b5; srl keeps srl with funct7b5 set
        s = idle(); s.in_valid = 1; s.cls = 2'b11; s.f3 = 3'b000; s.f7 = 1; s.d1 = 32'h5;
        drive(s);
        s.cls = 2'b10; s.f3 = 3'b101;
        drive(s);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s.in_valid  = ($urandom_range(0, 9) < 7);
            s.out_ready = ($urandom_range(0, 9) < 6);
            s.flush     = ($urandom_range(0, 99) < 8);
            s.reset     = ($urandom_range(0, 99) < 3);
            s.alu_src   = $urandom_range(0, 1);
            s.f7        = $urandom_range(0, 1);
            s.ewe       = $urandom_range(0, 1);
            s.mwe       = $urandom_range(0, 1);
            s.rs1       = 5'($urandom_range(0, 3));
            s.rs2       = 5'($urandom_range(0, 3));
            s.erd       = 5'($urandom_range(0, 3));
            s.mrd       = 5'($urandom_range(0, 3));
            s.d1        = $urandom;
            s.d2        = $urandom;
            s.imm       = $urandom;
            s.eres      = $urandom;
            s.mres      = $urandom;
            s.cls       = 2'($urandom_range(0, 3));
            s.f3        = 3'($urandom_range(0, 7));
            drive(s);
        end
        s = idle();
        repeat (4) drive(s);
        check("drain_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
